alu_seq_exec: RTL
=================

ALU_SEQ_EXEC -- requirements
Module: alu_seq_exec

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request to launch an operation.
REQ-005 SHALL have port alu_control  input  3  op select: 000 add, 001 sub, 010 mul, 011 div, other values treated as add.
REQ-006 SHALL have port a  input  WIDTH  operand A, unsigned.
REQ-007 SHALL have port b  input  WIDTH  operand B, unsigned.
REQ-008 SHALL have port busy  output  1  operation in progress, start ignored.
REQ-009 SHALL have port done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port result  output  WIDTH  registered result.
REQ-011 SHALL have port zero  output  1  result == 0, valid with result.
REQ-012 SHALL have port div_by_zero  output  1  last div had b == 0.

Function
REQ-013 SHALL implement FSM states IDLE, EXEC, DONE; busy = 1 only in EXEC.
REQ-014 SHALL accept start when busy == 0 (IDLE or DONE), capturing a, b, alu_control in that cycle; later input changes have no effect.
REQ-015 SHALL ignore start while busy == 1, with no queuing.
REQ-016 SHALL complete add/sub without EXEC: start accepted at cycle 0, done = 1 and result valid at cycle 1 (state DONE).
REQ-017 SHALL compute add/sub modulo 2^WIDTH; carry/borrow discarded.
REQ-018 SHALL perform mul as shift-add, one bit per cycle: EXEC for exactly WIDTH cycles, done at cycle WIDTH+1; result = low WIDTH bits of unsigned product.
REQ-019 SHALL perform div as restoring unsigned division, one quotient bit per cycle: EXEC for exactly WIDTH cycles, done at cycle WIDTH+1; result = quotient, remainder discarded.
REQ-020 SHALL, for div with b == 0, skip EXEC: done at cycle 1, result all ones, div_by_zero = 1.
REQ-021 SHALL clear div_by_zero on every accepted start and set it only per REQ-020.
REQ-022 SHALL update result and zero only on the done cycle, holding them until the next completion.
REQ-023 SHALL assert done for exactly one cycle per accepted operation; DONE returns to IDLE next cycle unless start is accepted.
REQ-024 SHALL, when start is accepted in DONE, begin the new operation immediately with no idle bubble; back-to-back adds give done every cycle.
REQ-025 SHALL use a WIDTH-bit iteration counter ending at WIDTH-1 without wrap-around into a new pass.

Reset
REQ-026 SHALL, on rst_n = 0, immediately force state IDLE, busy 0, done 0, result 0, zero 0, div_by_zero 0, counter 0.
REQ-027 SHALL abort any in-flight operation on reset with no done pulse; the first start after rst_n rises is accepted normally.

Structure
REQ-028 SHALL take op encodings (ALU_ADD, ALU_SUB, ALU_MUL, ALU_DIV), FSM state typedef and default WIDTH from shared package alu_pkg, also used by the ALU control decoder.
REQ-029 SHALL place the restoring divider datapath (partial remainder, quotient shift register) in sub-module alu_shift_divider, with the multiplier inline.

Verification (WIDTH = 32)
REQ-030 SHALL cover add 7+5 -> done at cycle 1, result 12, zero 0; sub 3-5 -> 0xFFFFFFFE; sub 9-9 -> 0, zero 1.
REQ-031 SHALL cover mul 123*456 -> busy cycles 1..32, done at cycle 33, result 56088; mul 0x10000*0x10000 -> result 0, zero 1.
REQ-032 SHALL cover div 100/7 -> done at cycle 33, result 14, div_by_zero 0; div 5/0 -> done at cycle 1, result 0xFFFFFFFF, div_by_zero 1.
REQ-033 SHALL cover start with add pulsed at cycle 5 of a div -> ignored; div result unchanged, one done only.
REQ-034 SHALL cover rst_n low at cycle 10 of a div -> all outputs 0 immediately, no done; a following add 1+1 -> result 2 at cycle 1.
REQ-035 SHALL cover start with add 2+2 held high on a mul's done cycle -> mul result then, next cycle, done again with result 4.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: op encodings, FSM states, default width
// and the alu_control decoder.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 32;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_MUL = 2'd2,
        ALU_DIV = 2'd3
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } alu_state_e;

    // Unused encodings fall back to add.
    function automatic alu_op_e alu_decode(input logic [2:0] ctrl);
        alu_op_e op;
        case (ctrl)
            3'b001:  op = ALU_SUB;
            3'b010:  op = ALU_MUL;
            3'b011:  op = ALU_DIV;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_shift_divider.sv
// Restoring unsigned divider datapath: one quotient bit per step, quotient bits shift in
// at the bottom of the register that holds the dividend.
module alu_shift_divider
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient_next
);

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_diff;
    logic             fits;

    assign rem_shift     = {rem_q, quot_q[WIDTH-1]};
    assign rem_diff      = rem_shift - {1'b0, dvsr_q};
    assign fits          = (rem_shift >= {1'b0, dvsr_q});
    assign quotient_next = {quot_q[WIDTH-2:0], fits};

    always_comb begin
        rem_d  = rem_q;
        quot_d = quot_q;
        dvsr_d = dvsr_q;
        if (load) begin
            rem_d  = '0;
            quot_d = dividend;
            dvsr_d = divisor;
        end else if (step) begin
            // A kept remainder is always below the divisor, so it fits in WIDTH bits.
            rem_d  = fits ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
            quot_d = quotient_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q  <= '0;
            quot_q <= '0;
            dvsr_q <= '0;
        end else begin
            rem_q  <= rem_d;
            quot_q <= quot_d;
            dvsr_q <= dvsr_d;
        end
    end

endmodule

// File: rtl/alu_seq_exec.sv
// Sequential ALU: single-cycle add/sub, WIDTH-cycle shift-add multiply and restoring
// divide, with a registered result and one-cycle done pulse.
module alu_seq_exec
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       alu_control,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             div_by_zero
);

    localparam logic [WIDTH-1:0] CntLast = WIDTH'(WIDTH - 1);

    alu_state_e       state_q, state_d;
    alu_op_e          op_q, op_d;
    alu_op_e          op_dec;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             dbz_q, dbz_d;
    logic             div_load;
    logic             div_step;
    logic [WIDTH-1:0] div_quot_next;

    assign op_dec   = alu_decode(alu_control);
    assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

    alu_shift_divider #(
        .WIDTH (WIDTH)
    ) u_div (
        .clk           (clk),
        .rst_n         (rst_n),
        .load          (div_load),
        .step          (div_step),
        .dividend      (a),
        .divisor       (b),
        .quotient_next (div_quot_next)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        result_d = result_q;
        zero_d   = zero_q;
        dbz_d    = dbz_q;
        div_load = 1'b0;
        div_step = 1'b0;

        case (state_q)
            EXEC: begin
                if (op_q == ALU_MUL) begin
                    acc_d    = acc_next;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                end else begin
                    div_step = 1'b1;
                end
                if (cnt_q == CntLast) begin
                    result_d = (op_q == ALU_MUL) ? acc_next : div_quot_next;
                    zero_d   = (result_d == '0);
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                // IDLE and DONE both accept a new operation.
                state_d = IDLE;
                if (start) begin
                    op_d  = op_dec;
                    cnt_d = '0;
                    dbz_d = 1'b0;
                    case (op_dec)
                        ALU_MUL: begin
                            mcand_d  = a;
                            mplier_d = b;
                            acc_d    = '0;
                            state_d  = EXEC;
                        end
                        ALU_DIV: begin
                            if (b == '0) begin
                                result_d = '1;
                                zero_d   = 1'b0;
                                dbz_d    = 1'b1;
                                state_d  = DONE;
                            end else begin
                                div_load = 1'b1;
                                state_d  = EXEC;
                            end
                        end
                        ALU_SUB: begin
                            result_d = a - b;
                            zero_d   = (result_d == '0);
                            state_d  = DONE;
                        end
                        default: begin
                            result_d = a + b;
                            zero_d   = (result_d == '0);
                            state_d  = DONE;
                        end
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= ALU_ADD;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            dbz_q    <= dbz_d;
        end
    end

    assign busy        = (state_q == EXEC);
    assign done        = (state_q == DONE);
    assign result      = result_q;
    assign zero        = zero_q;
    assign div_by_zero = dbz_q;

endmodule
